// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit instruction-memory writes while holding the core in reset
// Ports: clk, reset (sync, active-high); start requests a load (seen only when idle);
//   byte_in/byte_valid/byte_ready stream handshake; wr_en/wr_addr/wr_data one write per assembled word;
//   cpu_hold keeps the core in reset during a load; load_done completion pulse; len_err/chk_err sticky errors.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing byte equal to the XOR of all data bytes.
module imem_loader #(
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              len_err,
  output logic              chk_err
);
  localparam int IW = $clog2(MAX_WORDS + 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, CHK} state_t;
  localparam state_t AFTER_LAST = CHK;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE} state_t;
  localparam state_t AFTER_LAST = DONE;
`endif
  state_t state, state_n;
  logic [IW-1:0] n, word_idx;
  logic [1:0] byte_idx;
  logic take, len_bad, last, rx_n;
  assign take = byte_valid && byte_ready;
  assign len_bad = byte_in == 8'd0 || int'(byte_in) > MAX_WORDS;
  assign last = word_idx + IW'(1) == n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign rx_n = state_n inside {LEN, DATA, CHK};
`else
  assign rx_n = state_n inside {LEN, DATA};
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? LEN : IDLE;
      LEN:   state_n = take ? (len_bad ? IDLE : DATA) : LEN;
      DATA:  state_n = take && byte_idx == 2'd3 ? WRITE : DATA;
      WRITE: state_n = last ? AFTER_LAST : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:   state_n = take ? DONE : CHK;
`endif
      default: state_n = IDLE;
    endcase
  end
  // Handshake and strobes are registered from the next state so each is a clean flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= ADDR_W'(BASE_ADDR);
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      len_err    <= 1'b0;
      chk_err    <= 1'b0;
      n          <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      byte_ready <= rx_n;
      wr_en      <= state_n == WRITE;
      cpu_hold   <= state_n != IDLE && state_n != DONE;
      load_done  <= state_n == DONE;
      if (state == IDLE && start) begin
        len_err <= 1'b0;
        chk_err <= 1'b0;
      end
      if (state == LEN && take) begin
        len_err  <= len_bad;
        n        <= IW'(byte_in);
        word_idx <= '0;
        byte_idx <= '0;
      end
      if (state == DATA && take) begin
        wr_data[{byte_idx, 3'b000} +: 8] <= byte_in;
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == DATA && state_n == WRITE) wr_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx, 2'b00});
      if (state == WRITE) word_idx <= word_idx + IW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == LEN && take) csum <= '0;
      if (state == DATA && take) csum <= csum ^ byte_in;
      if (state == CHK && take) chk_err <= byte_in != csum;
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream loads checked every cycle against a byte-count based reference model
module tb_imem_loader;
  localparam int BASE = 0;
  localparam int MAXW = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic byte_ready, wr_en, cpu_hold, load_done, len_err, chk_err;
  logic [31:0] wr_addr, wr_data;
  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .len_err(len_err), .chk_err(chk_err)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [7:0] sq[$];
  logic [31:0] log_addr[$], log_data[$];
  int done_cnt = 0;
  int vmode = 0;
  bit tog = 1'b0;
  bit m_act, m_wr, m_done, m_len, m_chk, nw, nd;
  int m_cnt, m_n, k;
  logic [31:0] m_addr, m_data;
  logic [7:0] m_cs, b;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Model: a load is LEN byte, 4*N data bytes, optional trailer; a write cycle follows every 4th data byte.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_act = 0; m_wr = 0; m_done = 0; m_len = 0; m_chk = 0;
      m_cnt = 0; m_n = 0; m_addr = BASE; m_data = 0; m_cs = 0;
    end else begin
      nw = 0; nd = 0;
      if (m_wr) begin
        if (m_cnt == 1 + 4 * m_n && !CK) begin m_act = 0; nd = 1; end
      end else if (m_done) begin
      end else if (!m_act) begin
        if (start) begin m_act = 1; m_cnt = 0; m_len = 0; m_chk = 0; end
      end else if (byte_valid) begin
        b = byte_in;
        if (sq.size() > 0) void'(sq.pop_front());
        if (m_cnt == 0) begin
          if (b == 0 || b > MAXW) begin m_len = 1; m_act = 0; end
          else begin m_n = b; m_cnt = 1; m_cs = 0; end
        end else if (m_cnt <= 4 * m_n) begin
          k = m_cnt - 1;
          m_data[8*(k%4) +: 8] = b;
          m_cs ^= b;
          m_cnt++;
          if (k % 4 == 3) begin nw = 1; m_addr = BASE + 4 * (k / 4); end
        end else begin
          m_chk = b != m_cs; m_act = 0; nd = 1;
        end
      end
      m_wr = nw; m_done = nd;
    end
    chk("byte_ready", byte_ready, m_act && !m_wr);
    chk("wr_en", wr_en, m_wr);
    chk("cpu_hold", cpu_hold, m_act);
    chk("load_done", load_done, m_done);
    chk("len_err", len_err, m_len);
    chk("chk_err", chk_err, m_chk);
    chk("wr_addr", wr_addr, m_addr);
    if (m_wr || reset) chk("wr_data", wr_data, m_data);
    if (wr_en) begin log_addr.push_back(wr_addr); log_data.push_back(wr_data); end
    if (load_done) done_cnt++;
  end
  initial forever begin
    @(negedge clk); #1;
    tog = !tog;
    byte_valid = sq.size() > 0 && (vmode == 1 ? tog : $urandom_range(0, 3) != 0);
    byte_in = sq.size() > 0 ? sq[0] : 8'($urandom);
  end
  task automatic step(input int c = 1);
    repeat (c) begin @(negedge clk); #1; end
  endtask
  task automatic clear_logs;
    log_addr.delete(); log_data.delete(); done_cnt = 0;
  endtask
  task automatic wait_idle(input string nm);
    int t = 0;
    while ((m_act || m_wr || m_done || sq.size() > 0) && t < 3000) begin step(); t++; end
    checks++;
    if (t >= 3000) begin failures++; $display("FAIL %s timeout actual=busy required=idle", nm); end
  endtask
  task automatic wait_cnt(input int c);
    int t = 0;
    while (m_cnt < c && t < 1000) begin step(); t++; end
    checks++;
    if (t >= 1000) begin failures++; $display("FAIL wait_cnt timeout actual=%0d required=%0d", m_cnt, c); end
  endtask
  task automatic push_load(input logic [31:0] w[$], input int trailer);
    logic [7:0] cs = 8'd0;
    sq.push_back(8'(w.size()));
    foreach (w[i]) for (int j = 0; j < 4; j++) begin sq.push_back(w[i][8*j +: 8]); cs ^= w[i][8*j +: 8]; end
    if (CK) sq.push_back(trailer < 0 ? cs : 8'(trailer));
  endtask
  task automatic pulse_start;
    start = 1'b1; step(); start = 1'b0;
  endtask
  task automatic check_words(input string nm, input logic [31:0] w[$]);
    chk({nm, "_nwr"}, log_data.size(), w.size());
    foreach (w[i]) if (i < log_data.size()) begin
      chk({nm, "_addr"}, log_addr[i], BASE + 4 * i);
      chk({nm, "_data"}, log_data[i], w[i]);
    end
  endtask
  initial begin
    logic [31:0] w[$];
    int nn;
    step(3);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_cpu_hold", cpu_hold, 1'b0);
    reset = 1'b0;
    step(2);
    // single word
    clear_logs(); w = '{32'h00A00513};
    push_load(w, -1); pulse_start(); wait_idle("single");
    check_words("single", w);
    chk("single_model_data", m_data, 32'h00A00513);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_chk_err", chk_err, 1'b0);
    if (CK) begin
      clear_logs(); push_load(w, 8'h00); pulse_start(); wait_idle("bad_chk");
      chk("bad_chk_err", chk_err, 1'b1);
      chk("bad_chk_done", done_cnt, 1);
      chk("bad_chk_nwr", log_data.size(), 1);
    end
    // two words with alternating valid
    clear_logs(); vmode = 1; w = '{32'h00000013, 32'h00948663};
    push_load(w, -1); pulse_start(); wait_idle("two");
    check_words("two", w); vmode = 0;
    // illegal lengths
    foreach (w[i]) begin end
    for (int r = 0; r < 2; r++) begin
      clear_logs(); sq.push_back(r == 0 ? 8'h00 : 8'h11); pulse_start(); wait_idle("illegal");
      step(2);
      chk("illegal_len_err", len_err, 1'b1);
      chk("illegal_nwr", log_data.size(), 0);
      chk("illegal_done", done_cnt, 0);
      chk("illegal_hold", cpu_hold, 1'b0);
    end
    // reset mid-load
    clear_logs(); w = '{32'h11111111, 32'h22222222, 32'h33333333};
    push_load(w, -1); pulse_start(); wait_cnt(7);
    reset = 1'b1; step(); reset = 1'b0; sq.delete(); step();
    chk("midrst_nwr", log_data.size(), 1);
    chk("midrst_addr0", log_addr.size() > 0 ? log_addr[0] : 32'hFFFFFFFF, 32'h0);
    chk("midrst_hold", cpu_hold, 1'b0);
    chk("midrst_wr_addr", wr_addr, 32'h0);
    clear_logs(); w = '{32'hDEADBEEF, 32'h00100093};
    push_load(w, -1); pulse_start(); wait_idle("after_rst");
    check_words("after_rst", w);
    // start while busy
    clear_logs(); w = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678};
    push_load(w, -1); pulse_start(); wait_cnt(3); pulse_start(); wait_idle("busy_start");
    check_words("busy_start", w);
    chk("busy_done", done_cnt, 1);
    // randomized loads
    for (int r = 0; r < 24; r++) begin
      clear_logs(); w.delete(); vmode = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) begin
        nn = $urandom_range(0, 1) ? 0 : $urandom_range(MAXW + 1, 255);
        sq.push_back(8'(nn)); pulse_start(); wait_idle("rand_illegal");
        chk("rand_len_err", len_err, 1'b1);
        chk("rand_illegal_nwr", log_data.size(), 0);
      end else begin
        nn = $urandom_range(1, MAXW);
        for (int i = 0; i < nn; i++) w.push_back($urandom);
        push_load(w, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 255)) : -1);
        pulse_start(); wait_idle("rand");
        check_words("rand", w);
        chk("rand_done", done_cnt, 1);
        chk("rand_len_err", len_err, 1'b0);
      end
      step($urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
